// File: rtl/blockade_rom_loader_if.sv
// blockade_rom_loader_if: ioctl download port and ROM write port between the
// host-side ioctl block, the ROM loader and the blockade core.
// The master modport belongs to the host/test side and the slave modport belongs to the loader.
interface blockade_rom_loader_if #(
    parameter int ADDR_W = 14
);
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wr;
    logic              game_reset;
    logic              load_err;
    logic [15:0]       checksum;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, dn_addr, dn_data, dn_wr, game_reset, load_err, checksum
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, dn_addr, dn_data, dn_wr, game_reset, load_err, checksum
    );
endinterface

// File: rtl/blockade_rom_loader.sv
// blockade_rom_loader: turns the ioctl byte stream into paced dn_addr/dn_data/dn_wr
// writes. It keeps the core in reset while a download is pending, while it is active,
// and for POST_RST cycles after it ends.
// Optional feature: define BLOCKADE_LOADER_CHECKSUM_EN to build a 16-bit wrapping sum
// of the accepted bytes. Without that macro, checksum is a constant zero.
module blockade_rom_loader #(
    parameter int         ADDR_W    = 14,
    parameter int         WR_CYCLES = 2,
    parameter int         POST_RST  = 16,
    parameter logic [7:0] ROM_INDEX = 8'd0
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    blockade_rom_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_SETTLE,
        S_RUN
    } state_t;

    // One down-counter serves both the write hold and the settle window.
    localparam logic [7:0] WR_LOAD  = 8'(WR_CYCLES - 1);
    localparam logic [7:0] RST_LOAD = 8'(POST_RST - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic              game_reset_q;
    logic              wait_q;
    logic              dn_wr_q;
    logic [ADDR_W-1:0] dn_addr_q;
    logic [7:0]        dn_data_q;
    logic              load_err_q;

    logic match;
    logic in_range;
    logic accept;
    logic load_entry;

    assign match      = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
    assign in_range   = (bus.ioctl_addr >> ADDR_W) == '0;
    assign accept     = (state == S_LOAD) && bus.ioctl_wr && in_range;
    // A fresh download starts here. LOAD and WRITE are already inside a download.
    assign load_entry = match && (state == S_IDLE || state == S_SETTLE || state == S_RUN);

    // Main sequencer: download tracking, write pacing, settle window and the error flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            game_reset_q <= 1'b1;
            wait_q       <= 1'b0;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            load_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (match) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (accept) begin
                        dn_addr_q <= bus.ioctl_addr[ADDR_W-1:0];
                        dn_data_q <= bus.ioctl_dout;
                        dn_wr_q   <= 1'b1;
                        wait_q    <= 1'b1;
                        cnt       <= WR_LOAD;
                        state     <= S_WRITE;
                    end else if (bus.ioctl_wr) begin
                        // The address is outside the ROM, so the byte is dropped.
                        load_err_q <= 1'b1;
                    end else if (!bus.ioctl_download) begin
                        cnt   <= RST_LOAD;
                        state <= S_SETTLE;
                    end
                end
                S_WRITE: begin
                    // The host ignored ioctl_wait. The byte is lost, so flag it.
                    if (bus.ioctl_wr) load_err_q <= 1'b1;
                    if (cnt == 8'd0) begin
                        dn_wr_q <= 1'b0;
                        wait_q  <= 1'b0;
                        if (!bus.ioctl_download) begin
                            cnt   <= RST_LOAD;
                            state <= S_SETTLE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (match) begin
                        state <= S_LOAD;
                    end else if (cnt == 8'd0) begin
                        game_reset_q <= 1'b0;
                        state        <= S_RUN;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RUN: begin
                    if (match) begin
                        game_reset_q <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // The error flag belongs to a single download. It can only be set in LOAD
            // and WRITE, so clearing it here never collides with a set.
            if (load_entry) load_err_q <= 1'b0;
        end
    end

`ifdef BLOCKADE_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    // Add each accepted byte in the cycle its dn_wr pulse starts. The sum restarts with each download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)        sum_q <= '0;
        else if (load_entry) sum_q <= '0;
        else if (accept)     sum_q <= sum_q + {8'h00, bus.ioctl_dout};
    end

    assign bus.checksum = sum_q;
`else
    assign bus.checksum = 16'h0000;
`endif

    assign bus.ioctl_wait = wait_q;
    assign bus.dn_addr    = dn_addr_q;
    assign bus.dn_data    = dn_data_q;
    assign bus.dn_wr      = dn_wr_q;
    assign bus.game_reset = game_reset_q;
    assign bus.load_err   = load_err_q;
endmodule

// File: tb/tb_blockade_rom_loader.sv
// tb_blockade_rom_loader: random download sessions plus the boundary cases. A small
// model keeps, for each session, the list of bytes that should reach the ROM, the
// expected error flag and the byte sum. A monitor turns each dn_wr pulse into
// an {addr, data, length} record.
module tb_blockade_rom_loader;
    localparam int ADDR_W    = 14;
    localparam int WR_CYCLES = 2;
    localparam int POST_RST  = 16;

    typedef struct {
        int         len;
        logic [13:0] addr;
        logic [7:0]  data;
    } pulse_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    blockade_rom_loader_if #(.ADDR_W(ADDR_W)) bus();

    blockade_rom_loader #(
        .ADDR_W(ADDR_W), .WR_CYCLES(WR_CYCLES), .POST_RST(POST_RST), .ROM_INDEX(8'd0)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;

    pulse_t      pulse_q[$];
    pulse_t      exp_q[$];
    bit          exp_err;
    logic [15:0] exp_sum;
    int          unstable = 0;
    int          wait_mism = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: turn each dn_wr pulse into a record, and track whether ioctl_wait matches dn_wr.
    initial begin
        int          cur_len = 0;
        logic [13:0] cur_addr = '0;
        logic [7:0]  cur_data = '0;
        forever begin
            @(negedge clk_sys);
            if (bus.dn_wr) begin
                if (cur_len == 0) begin
                    cur_addr = bus.dn_addr;
                    cur_data = bus.dn_data;
                end else if (bus.dn_addr != cur_addr || bus.dn_data != cur_data) begin
                    unstable++;
                end
                cur_len++;
            end else if (cur_len != 0) begin
                pulse_q.push_back('{cur_len, cur_addr, cur_data});
                cur_len = 0;
            end
            if (bus.ioctl_wait !== bus.dn_wr) wait_mism++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.ioctl_wait && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 50) chk("wait_timeout", 32'd1, 32'd0);
    endtask

    // A well-behaved host write. When 'model' is set, the reference model records the write.
    task automatic host_wr(input logic [24:0] a, input logic [7:0] d, input bit model);
        wait_idle();
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        if (model) begin
            if (a < 25'h4000) begin
                exp_q.push_back('{WR_CYCLES, a[13:0], d});
                exp_sum += 16'(d);
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic start_session();
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        exp_err = 1'b0;
        exp_sum = 16'h0;
        @(negedge clk_sys);
        chk("start_game_reset", 32'(bus.game_reset), 32'd1);
        chk("start_err_clr", 32'(bus.load_err), 32'd0);
    endtask

    // Call this at the negedge where ioctl_download fell. 'exp_cnt' is the number of
    // sampled cycles that game_reset should stay high after the fall.
    task automatic settle_and_check(input string tag, input int exp_cnt);
        int n = 0;
        while (n < 300) begin
            @(negedge clk_sys);
            if (!bus.game_reset) break;
            n++;
        end
        chk({tag, ".settle"}, 32'(n), 32'(exp_cnt));
        chk({tag, ".npulse"}, 32'(pulse_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < pulse_q.size() && i < exp_q.size(); i++) begin
            chk({tag, ".addr"}, 32'(pulse_q[i].addr), 32'(exp_q[i].addr));
            chk({tag, ".data"}, 32'(pulse_q[i].data), 32'(exp_q[i].data));
            chk({tag, ".len"},  32'(pulse_q[i].len),  32'(exp_q[i].len));
        end
        chk({tag, ".load_err"}, 32'(bus.load_err), 32'(exp_err));
`ifdef BLOCKADE_LOADER_CHECKSUM_EN
        chk({tag, ".checksum"}, 32'(bus.checksum), 32'(exp_sum));
`else
        chk({tag, ".checksum"}, 32'(bus.checksum), 32'd0);
`endif
        pulse_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_session(input string tag);
        wait_idle();
        bus.ioctl_download = 1'b0;
        settle_and_check(tag, POST_RST);
    endtask

    initial begin
        int gr_low;
        int wait_hi;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        exp_err = 1'b0;
        exp_sum = '0;

        // Reset values
        repeat (3) @(negedge clk_sys);
        chk("rst.game_reset", 32'(bus.game_reset), 32'd1);
        chk("rst.wait",       32'(bus.ioctl_wait), 32'd0);
        chk("rst.dn_wr",      32'(bus.dn_wr),      32'd0);
        chk("rst.dn_addr",    32'(bus.dn_addr),    32'd0);
        chk("rst.dn_data",    32'(bus.dn_data),    32'd0);
        chk("rst.load_err",   32'(bus.load_err),   32'd0);
        chk("rst.checksum",   32'(bus.checksum),   32'd0);
        reset_n = 1'b1;

        // T1: 100 idle cycles with no download
        gr_low = 0; wait_hi = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (!bus.game_reset) gr_low++;
            if (bus.ioctl_wait) wait_hi++;
        end
        chk("t1.gr_low", 32'(gr_low), 32'd0);
        chk("t1.wait_hi", 32'(wait_hi), 32'd0);
        chk("t1.npulse", 32'(pulse_q.size()), 32'd0);

        // T2: write the two ends of the ROM address range
        start_session();
        host_wr(25'h0000, 8'hA5, 1'b1);
        host_wr(25'h3FFF, 8'h5A, 1'b1);
        finish_session("t2");

        // T3: an out-of-range byte sets load_err, the flag survives RUN, and the next start clears it
        start_session();
        host_wr(25'h0123, 8'h11, 1'b1);
        host_wr(25'h4000, 8'h77, 1'b1);
        host_wr(25'h1FFFFFF, 8'h33, 1'b1);
        finish_session("t3");
        repeat (5) @(negedge clk_sys);
        chk("t3.err_in_run", 32'(bus.load_err), 32'd1);
        chk("t3.running", 32'(bus.game_reset), 32'd0);

        // T4: download falls in the cycle right after ioctl_wr
        start_session();
        wait_idle();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0BEE; bus.ioctl_dout = 8'hC3;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        exp_q.push_back('{WR_CYCLES, 14'h0BEE, 8'hC3});
        exp_sum += 16'h00C3;
        settle_and_check("t4", POST_RST + 1);

        // T5: a download to another index leaves the core running
        bus.ioctl_index = 8'd1;
        bus.ioctl_download = 1'b1;
        gr_low = 0;
        for (int i = 0; i < 3; i++) begin
            host_wr(25'($urandom_range(0, 16'h3FFF)), 8'($urandom), 1'b0);
            if (!bus.game_reset) gr_low++;
        end
        repeat (3) @(negedge clk_sys);
        chk("t5.running", 32'(bus.game_reset), 32'd0);
        chk("t5.gr_low_cnt", 32'(gr_low), 32'd3);
        chk("t5.npulse", 32'(pulse_q.size()), 32'd0);
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        start_session();
        host_wr(25'h2000, 8'h42, 1'b1);
        finish_session("t5");

        // The host raises ioctl_wr during WRITE: that byte is ignored and the error is flagged
        start_session();
        wait_idle();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0100; bus.ioctl_dout = 8'h99;
        @(negedge clk_sys);
        bus.ioctl_addr = 25'h0200; bus.ioctl_dout = 8'h66;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        exp_q.push_back('{WR_CYCLES, 14'h0100, 8'h99});
        exp_sum += 16'h0099;
        exp_err = 1'b1;
        finish_session("viol");

        // Randomized sessions
        for (int s = 0; s < 12; s++) begin
            int nwr;
            nwr = $urandom_range(1, 8);
            start_session();
            for (int i = 0; i < nwr; i++) begin
                logic [24:0] a;
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                if ($urandom_range(0, 7) == 0) a = 25'h4000 + 25'($urandom_range(0, 32'h1FFBFFF));
                else                           a = 25'($urandom_range(0, 32'h3FFF));
                host_wr(a, 8'($urandom), 1'b1);
            end
            finish_session("rand");
        end

        // T6: asynchronous reset in the middle of a write
        start_session();
        wait_idle();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0555; bus.ioctl_dout = 8'hAA;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t6.dn_wr", 32'(bus.dn_wr), 32'd0);
        chk("t6.game_reset", 32'(bus.game_reset), 32'd1);
        chk("t6.wait", 32'(bus.ioctl_wait), 32'd0);
        bus.ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        gr_low = 0;
        repeat (30) begin
            @(negedge clk_sys);
            if (!bus.game_reset) gr_low++;
        end
        chk("t6.idle_gr_low", 32'(gr_low), 32'd0);
        pulse_q.delete();
        exp_q.delete();
        start_session();
        host_wr(25'h0555, 8'hAA, 1'b1);
        finish_session("t6");

        chk("pulse_stable", 32'(unstable), 32'd0);
        chk("wait_eq_dn_wr", 32'(wait_mism), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
